// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the shared-memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Owner encoding doubles as the index into the two-bit request vector.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; under contention the
// requester that was not served last wins.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: req[1:0] (bit0 = IF, bit1 = DM), last_owner, gnt[1:0] one-hot or zero.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  assign gnt[OWN_IF] = req[OWN_IF] & (~req[OWN_DM] | (last_owner == OWN_DM));
  assign gnt[OWN_DM] = req[OWN_DM] & (~req[OWN_IF] | (last_owner == OWN_IF));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (IF) and MMU (DM) paths onto one memory port, one
// transaction at a time, with a watchdog for unacknowledged requests.
// Latency: req->mem_req 1 cycle, mem_ack->valid 1 cycle; backpressure: requesters hold req until valid.
// Ports: clk, reset (async active-low), if_* fetch side, dm_* MMU side, mem_* memory side.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_valid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIM_SAT  = TW'(TIMEOUT);
  // Timer value during the last BUSY cycle the watchdog allows.
  localparam logic [TW-1:0] TIM_LAST = TW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic            owner, owner_nxt;
  logic            last_owner, last_owner_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [1:0]      gnt;

  logic                  mem_req_nxt, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic                  if_valid_nxt, if_err_nxt, dm_valid_nxt, dm_err_nxt;
  logic [DATA_WIDTH-1:0] if_rdata_nxt, dm_rdata_nxt;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  rr_arb2 u_rr_arb2 (
    .req        ({dm_req, if_req}),
    .last_owner (last_owner),
    .gnt        (gnt)
  );

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    timer_nxt      = timer;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    // Completion outputs are single-cycle pulses: zero unless entering RESP.
    if_valid_nxt   = 1'b0;
    if_rdata_nxt   = '0;
    if_err_nxt     = 1'b0;
    dm_valid_nxt   = 1'b0;
    dm_rdata_nxt   = '0;
    dm_err_nxt     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;

    case (state)
      IDLE: begin
        if (|gnt) begin
          owner_nxt      = gnt[OWN_DM];
          last_owner_nxt = gnt[OWN_DM];
          timer_nxt      = '0;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = gnt[OWN_DM] & dm_we;
          mem_addr_nxt   = gnt[OWN_DM] ? dm_addr : if_addr;
          mem_wdata_nxt  = gnt[OWN_DM] ? dm_wdata : '0;
          state_nxt      = BUSY;
        end
      end

      BUSY: begin
        if (timer != TIM_SAT) timer_nxt = timer + 1'b1;
        // Ack is checked first so an ack on the final allowed cycle wins.
        if (mem_ack || (timer == TIM_LAST)) begin
          resp_err      = ~mem_ack;
          resp_rdata    = (mem_ack && !mem_we) ? mem_rdata : '0;
          mem_req_nxt   = 1'b0;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = '0;
          mem_wdata_nxt = '0;
          if (owner == OWN_DM) begin
            dm_valid_nxt = 1'b1;
            dm_rdata_nxt = resp_rdata;
            dm_err_nxt   = resp_err;
          end else begin
            if_valid_nxt = 1'b1;
            if_rdata_nxt = resp_rdata;
            if_err_nxt   = resp_err;
          end
          state_nxt = RESP;
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt     = IDLE;
        mem_req_nxt   = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_DM;
      timer      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      dm_valid   <= 1'b0;
      dm_rdata   <= '0;
      dm_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      timer      <= timer_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_valid   <= if_valid_nxt;
      if_rdata   <= if_rdata_nxt;
      if_err     <= if_err_nxt;
      dm_valid   <= dm_valid_nxt;
      dm_rdata   <= dm_rdata_nxt;
      dm_err     <= dm_err_nxt;
    end
  end

endmodule
